cva5_fifo_drain_arbiter: RTL
============================

# cva5_fifo_drain_arbiter

Round-robin scheduler that shares one downstream consumer between several small FIFOs. Each FIFO exposes valid, full and data_out, and receives a pop from this block. The block selects at most one non-empty FIFO per cycle, pops it, and captures the head entry into a single output register that carries a valid/ready handshake. It sits between per-unit queues (for example divider, load-attribute and fetch-attribute FIFOs) and a shared writeback or retire port.

## Interface
- NUM_SRC, 3, number of source FIFOs; legal range 2..8
- DATA_WIDTH, 32, width of each FIFO entry and of out_data
- SRC_W, derived, $clog2(NUM_SRC); not overridable
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-high
- flush  in  1  discards the output-register contents and blocks pops for this cycle
- src_valid  in  NUM_SRC  FIFO i is non-empty
- src_full  in  NUM_SRC  FIFO i is full; used only when CVA5_FIFO_ARB_FULL_PRIO_EN is defined
- src_data  in  NUM_SRC x DATA_WIDTH  head entry of FIFO i; valid in the same cycle as src_valid[i]
- src_pop  out  NUM_SRC  one-hot or zero; combinational pop to FIFO i
- out_valid  out  1  output register holds an entry
- out_ready  in  1  consumer accepts the entry this cycle
- out_data  out  DATA_WIDTH  registered entry
- out_src  out  SRC_W  index of the FIFO the entry came from

## Operation
- Define load_en = ~flush & (~out_valid | out_ready).
- Define req = src_valid, masked to all-zero when load_en = 0.
- Round-robin pointer rr_ptr (SRC_W bits) names the highest-priority source. Search order is rr_ptr, rr_ptr+1, …, NUM_SRC-1, 0, …, rr_ptr-1.
- grant = first set bit of req in search order. src_pop = grant, so src_pop is never set for a source with src_valid = 0.
- On a grant to source g:
  - out_data <= src_data[g]
  - out_src <= g
  - out_valid <= 1
  - rr_ptr <= g+1, wrapping to 0 when g = NUM_SRC-1. This is explicit modular arithmetic; NUM_SRC need not be a power of two.
- With no grant: if out_valid & out_ready, then out_valid <= 0. Otherwise out_valid holds.
- With no grant: rr_ptr holds, and out_data and out_src hold.
- Flush (not reset): out_valid <= 0 and src_pop = 0. rr_ptr, out_data and out_src are unchanged. Flush has priority over out_ready.
- Simultaneous consume and refill (out_valid & out_ready & grant): the new entry replaces the old one, out_valid stays 1, and there is no bubble.
- The block never pops more than one FIFO per cycle.
- The block never changes out_data or out_src while out_valid & ~out_ready (the entry is stable under backpressure).

## Timing
- Reset values: out_valid = 0, out_data = 0, out_src = 0, rr_ptr = 0. src_pop = 0 during reset, because load_en is forced to 0 while rst is high.
- Reset mid-operation discards the held entry. It issues no pop in the reset cycle.
- src_pop is combinational from src_valid, src_full, out_valid, out_ready, flush and rr_ptr. There is no combinational path from src_data.
- Latency: an entry popped in cycle N is presented with out_valid = 1 in cycle N+1.
- Throughput: one entry per cycle when out_ready is held at 1.
- Fairness: with all sources continuously valid and out_ready = 1, each source is granted exactly once in every NUM_SRC consecutive grants.

## Configuration
- CVA5_FIFO_ARB_FULL_PRIO_EN defined:
  - Before the round-robin search, if any bit of (req & src_full) is set, the grant goes to the lowest-index such source.
  - rr_ptr still updates to g+1 as for any grant.
- Not defined:
  - src_full is ignored (left unconnected internally).
  - Pure round-robin is used.

## Test plan
- Reset, then src_valid = 3'b111 with out_ready = 1 for 6 cycles -> src_pop sequence 001, 010, 100, 001, 010, 100; out_src 0,1,2,0,1,2 one cycle later; out_valid = 1 from cycle 2 onward.
- Backpressure: after one grant to src 1 (data 0xA5A5_0001), hold out_ready = 0 for 4 cycles with src_valid = 3'b111 -> src_pop = 0 throughout; out_data stays 0xA5A5_0001 and out_src stays 1; on out_ready = 1 the next pop goes to src 2 in the same cycle.
- Flush while out_valid = 1 and src_valid = 3'b001 -> src_pop = 0 that cycle; out_valid = 0 next cycle; rr_ptr unchanged; src 0 is popped the following cycle.
- Sparse traffic: only src 2 valid, one cycle in every three -> each valid cycle (with the register empty) pops src 2; out_valid pulses for 1 cycle with out_ready = 1; rr_ptr wraps to 0.
- NUM_SRC = 3 wrap: grant to src 2 -> rr_ptr = 0, never 3. Check with src_valid = 3'b011: the next grant goes to src 0.
- With CVA5_FIFO_ARB_FULL_PRIO_EN defined: rr_ptr = 0, src_valid = 3'b111, src_full = 3'b100 -> grant goes to src 2, then rr_ptr = 0. Without the macro, the same stimulus grants src 0.

Source files
------------

// File: rtl/cva5_fifo_drain_arbiter.sv
// cva5_fifo_drain_arbiter
// Round-robin drain of several small FIFOs into one registered valid/ready
// output. At most one FIFO is popped per cycle, and its head entry is
// captured into the output register.
//
// Optional feature macro: CVA5_FIFO_ARB_FULL_PRIO_EN
//   When defined, a requesting FIFO that is also full takes priority
//   (lowest index first) before the round-robin search. When undefined,
//   src_full is ignored and pure round-robin is used.
module cva5_fifo_drain_arbiter #(
  parameter int NUM_SRC    = 3,
  parameter int DATA_WIDTH = 32,
  localparam int SRC_W     = $clog2(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC-1:0]            src_full,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]            src_pop,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [SRC_W-1:0]              out_src
);

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
  logic [SRC_W-1:0]      out_src_q,   out_src_d;
  logic [SRC_W-1:0]      rr_ptr_q,    rr_ptr_d;

  logic                  load_en;
  logic [NUM_SRC-1:0]    req;
  logic                  grant_any;
  logic [SRC_W-1:0]      grant_idx;
  logic [NUM_SRC-1:0]    grant_oh;

`ifndef CVA5_FIFO_ARB_FULL_PRIO_EN
  logic                  unused_src_full;
  assign unused_src_full = ^src_full;
`endif

  // The register may be refilled when empty or being drained; reset and flush block pops.
  assign load_en = ~rst & ~flush & (~out_valid_q | out_ready);
  assign req     = load_en ? src_valid : '0;

  // Pick one requester: optional full-priority pass, then round-robin from rr_ptr.
  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
`ifdef CVA5_FIFO_ARB_FULL_PRIO_EN
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!grant_any && req[i] && src_full[i]) begin
        grant_any = 1'b1;
        grant_idx = SRC_W'(i);
      end
    end
`endif
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_SRC) begin
        idx = idx - NUM_SRC;
      end
      if (!grant_any && req[idx]) begin
        grant_any = 1'b1;
        grant_idx = SRC_W'(idx);
      end
    end
  end

  // Expand the winning index into a one-hot pop vector.
  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      grant_oh[i] = grant_any && (grant_idx == SRC_W'(i));
    end
  end

  assign src_pop = grant_oh;

  // Next state of the output register and the round-robin pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    rr_ptr_d    = rr_ptr_q;
    if (grant_any) begin
      out_valid_d = 1'b1;
      out_data_d  = src_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
      out_src_d   = grant_idx;
      // Explicit wrap so a non-power-of-two source count never lands on an invalid index.
      if (grant_idx == SRC_W'(NUM_SRC - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_idx + SRC_W'(1);
      end
    end else if (flush) begin
      out_valid_d = 1'b0;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule
